// File: rtl/dispatcher_rr_n_if.sv
// Stream bundle for the 1-to-N round-robin dispatcher: one upstream stream in,
// N lane streams out.
interface dispatcher_rr_n_if #(
  parameter int DWIDTH = 16,
  parameter int N      = 2
);
  // Handshake: a beat moves on a rising clk edge where valid && ready; a
  // producer holding valid keeps valid and data stable until that edge, and
  // ready may depend combinationally on the consumer side only, never on valid.
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              out_valid [N];
  logic [DWIDTH-1:0] out_data  [N];
  logic              out_ready [N];

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dispatcher_rr_n.sv
// 1-to-N round-robin stream dispatcher: each accepted beat goes to the first
// free lane at or after ptr, into that lane's one-entry output register.
module dispatcher_rr_n #(
  parameter  int DWIDTH = 16,
  parameter  int N      = 2,
  localparam int PW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  dispatcher_rr_n_if.slave bus,
  output logic [PW-1:0]   ptr
);

  logic              vld  [N];
  logic [DWIDTH-1:0] dat  [N];
  logic [N-1:0]      free;
  logic [N-1:0]      rot;
  logic [PW-1:0]     pos;
  logic [PW:0]       sel_sum;
  logic [PW-1:0]     sel;
  logic              load;

  for (genvar j = 0; j < N; j++) begin : g_lane
    // A full lane being drained this cycle can take a new beat at the same edge.
    assign free[j]          = !vld[j] || bus.out_ready[j];
    assign bus.out_valid[j] = vld[j];
    assign bus.out_data[j]  = dat[j];
  end

  assign bus.in_ready = |free;
  assign load         = bus.in_valid && bus.in_ready;

  // Rotate free so bit 0 is lane ptr, take the first set bit, then map back
  // modulo N (N need not be a power of two).
  always_comb begin
    rot = N'({free, free} >> ptr);
    pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) pos = PW'(k);
    end
    sel_sum = {1'b0, ptr} + {1'b0, pos};
    if (sel_sum >= (PW+1)'(N)) sel_sum = sel_sum - (PW+1)'(N);
    sel = sel_sum[PW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      for (int j = 0; j < N; j++) begin
        vld[j] <= 1'b0;
        dat[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (load && (sel == PW'(j))) begin
          vld[j] <= 1'b1;
          dat[j] <= bus.in_data;
        end else if (vld[j] && bus.out_ready[j]) begin
          vld[j] <= 1'b0;
        end
      end
      if (load) ptr <= (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
    end
  end

endmodule

// File: tb/tb_dispatcher_rr_n.sv
// Directed bench for dispatcher_rr_n: N=4 instance driven from a vector table,
// N=3 instance for pointer wrap, plus an asynchronous mid-stream reset.
module tb_dispatcher_rr_n;

  logic clk;
  logic reset;

  dispatcher_rr_n_if #(.DWIDTH(16), .N(4)) if4 ();
  dispatcher_rr_n_if #(.DWIDTH(16), .N(3)) if3 ();
  logic [1:0] ptr4;
  logic [1:0] ptr3;

  dispatcher_rr_n #(.DWIDTH(16), .N(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave),
    .ptr   (ptr4)
  );

  dispatcher_rr_n #(.DWIDTH(16), .N(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3.slave),
    .ptr   (ptr3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic            in_valid;
    logic [15:0]     in_data;
    logic [3:0]      out_ready;
    logic            exp_in_ready;
    logic [3:0]      exp_valid;
    logic [1:0]      exp_ptr;
    logic [3:0][15:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [15:0] id, input logic [3:0] ordy,
                              input logic eir, input logic [3:0] ev, input logic [1:0] ep,
                              input logic [15:0] d3, input logic [15:0] d2,
                              input logic [15:0] d1, input logic [15:0] d0);
    vec_t v;
    v.in_valid     = iv;
    v.in_data      = id;
    v.out_ready    = ordy;
    v.exp_in_ready = eir;
    v.exp_valid    = ev;
    v.exp_ptr      = ep;
    v.exp_data     = {d3, d2, d1, d0};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] valid4();
    logic [3:0] v;
    for (int j = 0; j < 4; j++) v[j] = if4.out_valid[j];
    return v;
  endfunction

  function automatic logic [2:0] valid3();
    logic [2:0] v;
    for (int j = 0; j < 3; j++) v[j] = if3.out_valid[j];
    return v;
  endfunction

  // driver: inputs at negedge, in_ready checked before the edge, state after it
  task automatic apply4(input vec_t v, input string tag);
    @(negedge clk);
    if4.in_valid = v.in_valid;
    if4.in_data  = v.in_data;
    for (int j = 0; j < 4; j++) if4.out_ready[j] = v.out_ready[j];
    #1;
    check({tag, " in_ready"}, 64'(if4.in_ready), 64'(v.exp_in_ready));
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, 64'(valid4()), 64'(v.exp_valid));
    check({tag, " ptr"}, 64'(ptr4), 64'(v.exp_ptr));
    for (int j = 0; j < 4; j++)
      check($sformatf("%s out_data[%0d]", tag, j), 64'(if4.out_data[j]), 64'(v.exp_data[j]));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " out_valid4"}, 64'(valid4()), 64'h0);
    check({tag, " ptr4"}, 64'(ptr4), 64'h0);
    for (int j = 0; j < 4; j++)
      check($sformatf("%s out_data4[%0d]", tag, j), 64'(if4.out_data[j]), 64'h0);
    check({tag, " out_valid3"}, 64'(valid3()), 64'h0);
    check({tag, " ptr3"}, 64'(ptr3), 64'h0);
  endtask

  initial begin
    reset       = 1'b0;
    if4.in_valid = 1'b0;
    if4.in_data  = '0;
    if3.in_valid = 1'b0;
    if3.in_data  = '0;
    for (int j = 0; j < 4; j++) if4.out_ready[j] = 1'b0;
    for (int j = 0; j < 3; j++) if3.out_ready[j] = 1'b0;

    // round-robin fill, stall on full
    vecs.push_back(mk(1, 16'hA0, 4'b0000, 1, 4'b0001, 1, 16'h0,  16'h0,  16'h0,  16'hA0));
    vecs.push_back(mk(1, 16'hA1, 4'b0000, 1, 4'b0011, 2, 16'h0,  16'h0,  16'hA1, 16'hA0));
    vecs.push_back(mk(1, 16'hA2, 4'b0000, 1, 4'b0111, 3, 16'h0,  16'hA2, 16'hA1, 16'hA0));
    vecs.push_back(mk(1, 16'hA3, 4'b0000, 1, 4'b1111, 0, 16'hA3, 16'hA2, 16'hA1, 16'hA0));
    vecs.push_back(mk(1, 16'hA4, 4'b0000, 0, 4'b1111, 0, 16'hA3, 16'hA2, 16'hA1, 16'hA0));
    // drain lanes 2,3 then skip busy lanes 0,1
    vecs.push_back(mk(0, 16'h0,  4'b1100, 1, 4'b0011, 0, 16'hA3, 16'hA2, 16'hA1, 16'hA0));
    vecs.push_back(mk(1, 16'hB0, 4'b0000, 1, 4'b0111, 3, 16'hA3, 16'hB0, 16'hA1, 16'hA0));
    vecs.push_back(mk(1, 16'hB1, 4'b0000, 1, 4'b1111, 0, 16'hB1, 16'hB0, 16'hA1, 16'hA0));
    // only lane 1 drains: same-cycle drain+load every cycle
    vecs.push_back(mk(1, 16'hC0, 4'b0010, 1, 4'b1111, 2, 16'hB1, 16'hB0, 16'hC0, 16'hA0));
    for (int c = 1; c < 8; c++)
      vecs.push_back(mk(1, 16'(16'hC0 + c), 4'b0010, 1, 4'b1111, 2,
                        16'hB1, 16'hB0, 16'(16'hC0 + c), 16'hA0));
    // drain everything, then refill to leave ptr non-zero
    vecs.push_back(mk(0, 16'h0,  4'b1111, 1, 4'b0000, 2, 16'hB1, 16'hB0, 16'hC7, 16'hA0));
    vecs.push_back(mk(1, 16'hE0, 4'b1111, 1, 4'b0100, 3, 16'hB1, 16'hE0, 16'hC7, 16'hA0));
    vecs.push_back(mk(1, 16'hE1, 4'b1111, 1, 4'b1000, 0, 16'hE1, 16'hE0, 16'hC7, 16'hA0));
    vecs.push_back(mk(1, 16'hD0, 4'b0000, 1, 4'b1001, 1, 16'hE1, 16'hE0, 16'hC7, 16'hD0));
    vecs.push_back(mk(1, 16'hD1, 4'b0000, 1, 4'b1011, 2, 16'hE1, 16'hE0, 16'hD1, 16'hD0));

    // reset / idle
    repeat (3) @(posedge clk);
    #1;
    check_cleared("in_reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_cleared("post_reset");
    check("post_reset in_ready4", 64'(if4.in_ready), 64'h1);
    check("post_reset in_ready3", 64'(if3.in_ready), 64'h1);

    for (int i = 0; i < vecs.size(); i++) apply4(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset between edges, checked before any clock edge
    @(negedge clk);
    if4.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_cleared("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply4(mk(1, 16'hD2, 4'b0000, 1, 4'b0001, 1, 16'h0, 16'h0, 16'h0, 16'hD2), "after_reset");
    @(negedge clk);
    if4.in_valid = 1'b0;

    // N=3 wrap with all lanes always ready
    for (int j = 0; j < 3; j++) if3.out_ready[j] = 1'b1;
    for (int b = 0; b < 7; b++) begin
      int lane;
      lane = b % 3;
      @(negedge clk);
      if3.in_valid = 1'b1;
      if3.in_data  = 16'(16'h30 + b);
      #1;
      check($sformatf("wrap%0d in_ready", b), 64'(if3.in_ready), 64'h1);
      @(posedge clk);
      #1;
      check($sformatf("wrap%0d out_valid", b), 64'(valid3()), 64'(3'b001 << lane));
      check($sformatf("wrap%0d out_data", b), 64'(if3.out_data[lane]), 64'(16'h30 + b));
      check($sformatf("wrap%0d ptr", b), 64'(ptr3), 64'((lane + 1) % 3));
    end
    @(negedge clk);
    if3.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
